mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width; storage depth is 2^ADDR_W words of 16 bits.
REQ-002 Parameter LATENCY, default 4: clock edges from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  requester presents a request this cycle.
REQ-006 req_wr  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  16  byte address; word index is req_addr[ADDR_W:1].
REQ-008 req_wdata  input  16  write data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 resp_valid  output  1  one-cycle pulse; a response is present.
REQ-011 resp_rdata  output  16  read data, or echoed write data.
REQ-012 resp_err  output  1  request was illegal; valid only with resp_valid.

Function
REQ-013 Three states: IDLE, BUSY, RESP; state is encoded in flops.
REQ-014 req_ready SHALL be 1 in IDLE only, driven from state with no combinational path from req_*.
REQ-015 Acceptance: IDLE with req_valid=1 at a rising edge; req_wr, req_addr and req_wdata are captured into internal registers at that edge; next state BUSY with counter loaded to LATENCY-1.
REQ-016 IDLE with req_valid=0: remain IDLE and capture nothing.
REQ-017 BUSY: counter decrements each edge; at the edge where counter==0, go to RESP. Inputs are ignored throughout BUSY and RESP.
REQ-018 resp_valid SHALL rise exactly LATENCY edges after the accepting edge and stay high for exactly one cycle (the RESP state); RESP -> IDLE unconditionally.
REQ-019 Maximum throughput is one request per LATENCY+2 cycles. Back-to-back requests: the next acceptance may occur on the edge leaving RESP+1 (the first IDLE cycle).
REQ-020 Error condition: captured addr[0]=1 (misaligned) or any of captured addr[15:ADDR_W+1] nonzero (out of range). The response then carries resp_err=1 and resp_rdata=0x0000, and storage is not modified.
REQ-021 Legal read: resp_rdata = storage[word index] as it stands at the BUSY->RESP edge.
REQ-022 Legal write: storage[word index] is written with the captured wdata at the BUSY->RESP edge; resp_rdata = the captured wdata.
REQ-023 resp_rdata and resp_err SHALL be registered and hold their values after the pulse until the next response or reset.
REQ-024 Changes to req_* after acceptance SHALL NOT affect the in-flight request.
REQ-025 With LATENCY=1, BUSY lasts one cycle and resp_valid rises on the edge after acceptance.

Reset
REQ-026 While rst=1 at an edge: state=IDLE, counter=0, resp_valid=0, resp_rdata=0x0000, resp_err=0, and all storage words are cleared to 0x0000.
REQ-027 rst takes priority over every other event, including an acceptance in the same cycle.
REQ-028 Reset mid-operation (BUSY or RESP) aborts the request: no response pulse and no storage write; req_ready=1 in the first cycle after reset.

Verification
REQ-029 Write 0xBEEF to addr 0x0010 and release; 2 idle cycles; then read 0x0010 -> each resp_valid fires exactly 4 edges after acceptance; the read returns 0xBEEF with resp_err=0.
REQ-030 Read of an address never written after reset (0x0020) -> resp_rdata=0x0000 and resp_err=0.
REQ-031 Write to 0x0003 (misaligned) or 0x0400 (out of range with ADDR_W=8) -> resp_err=1 and resp_rdata=0; a subsequent read of 0x0002 or 0x0000 returns the prior contents unchanged.
REQ-032 Hold req_valid=1 continuously with changing addresses -> exactly one acceptance per 6 cycles; req_ready=0 throughout BUSY and RESP; each response matches the request captured at acceptance.
REQ-033 Assert rst during the 2nd BUSY cycle of a write to 0x0008 -> no resp_valid pulse; a later read of 0x0008 returns 0x0000.
REQ-034 LATENCY=1 build: read request -> resp_valid on the edge after acceptance; req_ready high again 2 cycles after acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory behind a fixed-latency request/response handshake.
// One request in flight at a time: IDLE accepts, BUSY counts down, RESP pulses the answer.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic              addr_err;
  logic              mem_we;

  assign word_idx = addr_q[ADDR_W:1];
  // Misaligned byte address, or any bit above the storage range set.
  assign addr_err = addr_q[0] | ((addr_q >> (ADDR_W + 1)) != 16'd0);

  // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          err_d   = addr_err;
          // Reads see the word as it stands before this edge's write.
          rdata_d = addr_err ? 16'h0000 : (wr_q ? wdata_q : mem_q[word_idx]);
          mem_we  = wr_q & ~addr_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      // NOTE: storage must read back zero after reset, so it is built from resettable flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (mem_we) mem_q[word_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table on a LATENCY=4 instance,
// plus back-to-back, mid-operation reset and a LATENCY=1 instance.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [15:0] resp_rdata;

  logic        d1_valid, d1_wr;
  logic [15:0] d1_addr, d1_wdata;
  logic        d1_ready, d1_resp_valid, d1_resp_err;
  logic [15:0] d1_resp_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(d1_valid), .req_wr(d1_wr), .req_addr(d1_addr), .req_wdata(d1_wdata),
    .req_ready(d1_ready), .resp_valid(d1_resp_valid), .resp_rdata(d1_resp_rdata), .resp_err(d1_resp_err)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One transaction on the LATENCY=4 instance; req_* are scrambled and req_valid held
  // high after acceptance so any leakage into the in-flight request shows up.
  task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [15:0] exp_rd, input logic exp_err, input string name);
    int   lat;
    logic ready_seen;
    @(negedge clk);
    check({name, " ready"}, req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_wr = ~wr; req_addr = addr ^ 16'h0002; req_wdata = ~wdata;
    lat = 0; ready_seen = 1'b0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      ready_seen |= req_ready;
      @(posedge clk); #1;
      lat++;
    end
    ready_seen |= req_ready;
    req_valid = 1'b0;
    check({name, " latency"}, lat, 4);
    check({name, " rdata"}, resp_rdata, exp_rd);
    check({name, " err"}, resp_err, exp_err);
    check({name, " ready low in flight"}, ready_seen, 0);
    @(posedge clk); #1;
    check({name, " pulse width"}, resp_valid, 0);
    check({name, " rdata hold"}, resp_rdata, exp_rd);
    check({name, " ready back"}, req_ready, 1);
  endtask

  task automatic watch_no_resp(input string name);
    logic seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [15:0] exp_q[$];
    int last_acc, n_acc, n_resp;

    vecs = '{
      '{1'b1, 16'h0010, 16'hBEEF, 16'hBEEF, 1'b0},
      '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0},
      '{1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0},
      '{1'b1, 16'h0002, 16'h1234, 16'h1234, 1'b0},
      '{1'b1, 16'h0003, 16'hDEAD, 16'h0000, 1'b1},
      '{1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0},
      '{1'b1, 16'h0400, 16'hCAFE, 16'h0000, 1'b1},
      '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0},
      '{1'b1, 16'h01FE, 16'hA5A5, 16'hA5A5, 1'b0},
      '{1'b0, 16'h01FE, 16'h0000, 16'hA5A5, 1'b0},
      '{1'b1, 16'h0000, 16'h1111, 16'h1111, 1'b0},
      '{1'b1, 16'h0200, 16'h2222, 16'h0000, 1'b1},
      '{1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0},
      '{1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1},
      '{1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1}
    };

    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    d1_valid = 1'b0; d1_wr = 1'b0; d1_addr = '0; d1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset ready", req_ready, 1);
    check("reset resp_valid", resp_valid, 0);
    check("reset rdata", resp_rdata, 16'h0000);
    check("reset err", resp_err, 0);

    foreach (vecs[i]) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
          $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Continuous req_valid with a new write every cycle: one acceptance per 6 cycles.
    last_acc = -1; n_acc = 0; n_resp = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) check("b2b unexpected resp", 1, 0);
        else check("b2b rdata", resp_rdata, exp_q.pop_front());
        check("b2b err", resp_err, 0);
      end
      if (req_ready) begin
        if (last_acc >= 0) check("b2b gap", c - last_acc, 6);
        last_acc = c;
        n_acc++;
        exp_q.push_back(16'h5000 + 16'(c));
      end
      req_valid = 1'b1; req_wr = 1'b1;
      req_addr  = 16'h0040 + 16'(2 * c);
      req_wdata = 16'h5000 + 16'(c);
    end
    req_valid = 1'b0;
    check("b2b acceptances", n_acc, 4);
    check("b2b responses", n_resp, 4);
    txn(1'b0, 16'h0040, 16'h0000, 16'h5000, 1'b0, "b2b readback0");
    txn(1'b0, 16'h0058, 16'h0000, 16'h500C, 1'b0, "b2b readback12");
    txn(1'b0, 16'h0042, 16'h0000, 16'h0000, 1'b0, "b2b not accepted");

    // Reset during the second BUSY cycle of a write aborts it and clears storage.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0008; req_wdata = 16'h7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst ready", req_ready, 1);
    check("midrst rdata cleared", resp_rdata, 16'h0000);
    watch_no_resp("midrst no pulse");
    txn(1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0, "midrst read 0008");
    txn(1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0, "midrst read 0010");

    // Reset wins over an acceptance on the same edge.
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h000A; req_wdata = 16'h4444;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rstacc ready", req_ready, 1);
    watch_no_resp("rstacc no pulse");
    txn(1'b0, 16'h000A, 16'h0000, 16'h0000, 1'b0, "rstacc read 000A");

    // LATENCY=1 instance: write then read back.
    @(negedge clk);
    check("lat1 ready", d1_ready, 1);
    d1_valid = 1'b1; d1_wr = 1'b1; d1_addr = 16'h0004; d1_wdata = 16'h9ABC;
    @(posedge clk); #1;
    d1_valid = 1'b0; d1_wdata = 16'h0000;
    check("lat1 wr busy", d1_resp_valid, 0);
    check("lat1 wr busy ready", d1_ready, 0);
    @(posedge clk); #1;
    check("lat1 wr resp", d1_resp_valid, 1);
    check("lat1 wr rdata", d1_resp_rdata, 16'h9ABC);
    @(posedge clk); #1;
    check("lat1 wr ready back", d1_ready, 1);
    check("lat1 wr pulse width", d1_resp_valid, 0);
    @(negedge clk);
    d1_valid = 1'b1; d1_wr = 1'b0; d1_addr = 16'h0004;
    @(posedge clk); #1;
    d1_valid = 1'b0;
    check("lat1 rd busy", d1_resp_valid, 0);
    @(posedge clk); #1;
    check("lat1 rd resp", d1_resp_valid, 1);
    check("lat1 rd rdata", d1_resp_rdata, 16'h9ABC);
    check("lat1 rd err", d1_resp_err, 0);
    check("lat1 rd ready in resp", d1_ready, 0);
    @(posedge clk); #1;
    check("lat1 rd ready back", d1_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
